// File: rtl/ans_job_ctrl_if.sv
// Valid/ready stream bundle. The master drives data and vld, the slave drives rdy.
interface ans_job_ctrl_if #(
  parameter int unsigned W = 4
);
  logic [W-1:0] data;
  logic         vld;
  logic         rdy;

  modport master (output data, output vld, input rdy);
  modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/ans_job_ctrl.sv
// Job sequencer in front of the ans core: optional table load, N symbols, then drain of core
// output until it has been quiet for QUIET cycles. Both streams pass through with no buffering.
module ans_job_ctrl #(
  parameter int unsigned SYM_W = 4,
  parameter int unsigned N_CNT = 16,
  parameter int unsigned LEN_W = 12,
  parameter int unsigned QUIET = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic             skip_load,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  ans_job_ctrl_if.slave    h_in,
  ans_job_ctrl_if.master   h_out,
  output logic [1:0]       core_cmd,
  ans_job_ctrl_if.master   core_in,
  ans_job_ctrl_if.slave    core_out,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] out_count
);

  localparam int unsigned LdW = (N_CNT > 1) ? $clog2(N_CNT) : 1;
  localparam int unsigned QW  = $clog2(QUIET + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDrain} state_e;

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LdW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [LEN_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [QW-1:0]      q_cnt_q, q_cnt_d;
  logic [LEN_W-1:0]   out_count_q, out_count_d;
  logic               done_q, done_d;

  logic               g_in, g_out, in_hs, out_hs;
  logic [SYM_W-1:0]   in_data, out_data;

  // Stream gating: inputs open in LOAD/RUN, outputs open in RUN/DRAIN.
  always_comb begin
    g_in          = (state_q == StLoad) || (state_q == StRun);
    g_out         = (state_q == StRun) || (state_q == StDrain);
    in_data       = h_in.data;
    out_data      = core_out.data;
    core_in.data  = in_data;
    core_in.vld   = h_in.vld & g_in;
    h_in.rdy      = core_in.rdy & g_in;
    h_out.data    = out_data;
    h_out.vld     = core_out.vld & g_out;
    core_out.rdy  = h_out.rdy & g_out;
    in_hs         = h_in.vld & h_in.rdy;
    out_hs        = h_out.vld & h_out.rdy;
  end

  // Command decode from registered state only, so it cannot glitch within a state.
  always_comb begin
    core_cmd = 2'b00;
    unique case (state_q)
      StIdle:          core_cmd = 2'b00;
      StLoad:          core_cmd = 2'b11;
      StRun, StDrain:  core_cmd = op_q ? 2'b10 : 2'b01;
      default:         core_cmd = 2'b00;
    endcase
  end

  // Next-state logic; abort overrides every transition and suppresses done.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    ld_cnt_d    = ld_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    q_cnt_d     = q_cnt_q;
    out_count_d = out_count_q;
    done_d      = 1'b0;

    if (out_hs && (out_count_q != {LEN_W{1'b1}})) begin
      out_count_d = out_count_q + LEN_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        // An abort alongside start leaves the previous job's count untouched.
        if (start && !abort) begin
          op_d        = op;
          len_d       = len;
          ld_cnt_d    = '0;
          sym_cnt_d   = '0;
          q_cnt_d     = '0;
          out_count_d = '0;
          if (!skip_load) begin
            state_d = StLoad;
          end else if (len != '0) begin
            state_d = StRun;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StLoad: begin
        if (in_hs) begin
          ld_cnt_d = ld_cnt_q + LdW'(1);
          if (ld_cnt_q == LdW'(N_CNT - 1)) begin
            state_d = (len_q != '0) ? StRun : StDrain;
          end
        end
      end
      StRun: begin
        if (in_hs) begin
          sym_cnt_d = sym_cnt_q + LEN_W'(1);
          if (sym_cnt_q == len_q - LEN_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (core_out.vld) begin
          q_cnt_d = '0;
        end else begin
          q_cnt_d = q_cnt_q + QW'(1);
          if (q_cnt_q + QW'(1) == QW'(QUIET)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
  end

  // State and job registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= 1'b0;
      len_q       <= '0;
      ld_cnt_q    <= '0;
      sym_cnt_q   <= '0;
      q_cnt_q     <= '0;
      out_count_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      ld_cnt_q    <= ld_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      q_cnt_q     <= q_cnt_d;
      out_count_q <= out_count_d;
      done_q      <= done_d;
    end
  end

  // Status outputs.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = done_q;
    out_count = out_count_q;
  end

endmodule
